// File: rtl/channel_model.sv
// Noisy sampled channel: a slow strobe latches the transmit word, adds LFSR-derived
// triangular noise and drives the saturated result with a one-cycle valid pulse.
module channel_model #(
    parameter int          CLK_DIV     = 5000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          NOISE_SHIFT = 0,
    parameter bit          NOISE_EN    = 1'b1
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [15:0] channel_input,
    output logic [15:0] channel_output,
    output logic        sample_valid
);

    localparam int              DIV      = (CLK_DIV < 2) ? 2 : CLK_DIV;
    localparam int              CNT_W    = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [15:0]     SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam int              SHIFT    = (NOISE_SHIFT > 6) ? 6 :
                                           ((NOISE_SHIFT < 0) ? 0 : NOISE_SHIFT);

    logic [CNT_W-1:0]   div_cnt;
    logic [15:0]        lfsr;
    logic               strobe_p0;
    logic signed [9:0]  raw_noise_p0;
    logic signed [17:0] noise_p0;
    logic signed [17:0] sum_p0;
    logic [15:0]        sat_p0;
    logic               vld_p1;

    // Fibonacci step for x^16+x^14+x^13+x^11+1; an all-zero state is locked up, so reseed.
    function automatic logic [15:0] lfsr_step(input logic [15:0] state);
        logic [15:0] next;
        if (state == 16'h0000) begin
            next = 16'h0001;
        end else begin
            next = {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
        end
        return next;
    endfunction

    function automatic logic [15:0] saturate_u16(input logic signed [17:0] value);
        logic [15:0] result;
        if (value < 18'sd0) begin
            result = 16'h0000;
        end else if (value > 18'sd65535) begin
            result = 16'hFFFF;
        end else begin
            result = value[15:0];
        end
        return result;
    endfunction

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (strobe_p0) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            lfsr <= SEED;
        end else begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    // Stage p0: noise shaping and saturation from the current input and LFSR state
    always_comb begin
        strobe_p0    = (div_cnt == CNT_LAST);
        raw_noise_p0 = $signed({{2{lfsr[7]}}, lfsr[7:0]})
                     + $signed({{2{lfsr[15]}}, lfsr[15:8]});
        noise_p0     = '0;
        if (NOISE_EN) begin
            noise_p0 = $signed({{8{raw_noise_p0[9]}}, raw_noise_p0}) <<< SHIFT;
        end
        sum_p0 = $signed({2'b00, channel_input}) + noise_p0;
        sat_p0 = saturate_u16(sum_p0);
    end

    // Stage p1: output register updates only on the strobe edge
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            channel_output <= 16'h0000;
            vld_p1         <= 1'b0;
        end else begin
            vld_p1 <= strobe_p0;
            if (strobe_p0) begin
                channel_output <= sat_p0;
            end
        end
    end

    assign sample_valid = vld_p1;

endmodule

// File: tb/tb_channel_model.sv
// Bench for channel_model: three parameterisations share stimulus and are compared
// every cycle against an arithmetic reference model of the sampled noisy channel.
module tb_channel_model;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] din;
    logic [15:0] out_clean, out_n0, out_n6;
    logic        vld_clean, vld_n0, vld_n6;

    always #5 clk = ~clk;

    channel_model #(.CLK_DIV(4), .LFSR_SEED(SEED), .NOISE_SHIFT(0), .NOISE_EN(1'b0)) dut_clean (
        .CLOCK_50(clk), .reset(reset), .channel_input(din),
        .channel_output(out_clean), .sample_valid(vld_clean));
    channel_model #(.CLK_DIV(4), .LFSR_SEED(SEED), .NOISE_SHIFT(0), .NOISE_EN(1'b1)) dut_n0 (
        .CLOCK_50(clk), .reset(reset), .channel_input(din),
        .channel_output(out_n0), .sample_valid(vld_n0));
    channel_model #(.CLK_DIV(4), .LFSR_SEED(SEED), .NOISE_SHIFT(6), .NOISE_EN(1'b1)) dut_n6 (
        .CLOCK_50(clk), .reset(reset), .channel_input(din),
        .channel_output(out_n6), .sample_valid(vld_n6));

    int          checks = 0;
    int          passed = 0;
    int          fails  = 0;
    int          edge_n;
    logic [15:0] ref_lfsr;
    int          exp_clean, exp_n0, exp_n6;
    bit          exp_vld;
    int          rec_q[$];
    int          rec_mode;
    int          rec_idx;
    int          st_n, st_sum, st_maxdev, st_first, st_min6, st_max6, st_sat6, st_zero6;
    bit          st_varied;

    // Polynomial x^16+x^14+x^13+x^11+1: new bit from taps 16,14,13,11 enters at the bottom.
    function automatic logic [15:0] ref_next(input logic [15:0] l);
        if (l == 16'h0000) return 16'h0001;
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic int ref_sample(input int in_val, input logic [15:0] l,
                                      input bit en, input int shift);
        int lo, hi, s;
        lo = int'(l[7:0]);
        hi = int'(l[15:8]);
        if (lo > 127) lo -= 256;
        if (hi > 127) hi -= 256;
        s = in_val + (en ? (lo + hi) * (1 << shift) : 0);
        if (s < 0) return 0;
        if (s > 65535) return 65535;
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        edge_n    = 0;
        ref_lfsr  = SEED;
        exp_clean = 0;
        exp_n0    = 0;
        exp_n6    = 0;
        exp_vld   = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out_clean"}, 32'(out_clean), 32'd0);
        check({tag, "_out_n0"},    32'(out_n0),    32'd0);
        check({tag, "_out_n6"},    32'(out_n6),    32'd0);
        check({tag, "_vld_clean"}, 32'(vld_clean), 32'd0);
        check({tag, "_vld_n0"},    32'(vld_n0),    32'd0);
        check({tag, "_vld_n6"},    32'(vld_n6),    32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_zero("mid_reset");
        reset = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic stat_reset();
        st_n = 0; st_sum = 0; st_maxdev = 0; st_first = 0; st_varied = 1'b0;
        st_min6 = 65536; st_max6 = -1; st_sat6 = 0; st_zero6 = 0;
    endtask

    task automatic run(input int n, input logic [15:0] val);
        bit strobe;
        int dev;
        for (int i = 0; i < n; i++) begin
            din = val;
            edge_n++;
            strobe = (edge_n % 4 == 0);
            if (strobe) begin
                exp_clean = ref_sample(int'(val), ref_lfsr, 1'b0, 0);
                exp_n0    = ref_sample(int'(val), ref_lfsr, 1'b1, 0);
                exp_n6    = ref_sample(int'(val), ref_lfsr, 1'b1, 6);
                if (rec_mode == 1 && rec_q.size() < 16) rec_q.push_back(exp_n0);
            end
            exp_vld  = strobe;
            ref_lfsr = ref_next(ref_lfsr);
            @(negedge clk);
            check("out_clean", 32'(out_clean), 32'(exp_clean));
            check("out_n0",    32'(out_n0),    32'(exp_n0));
            check("out_n6",    32'(out_n6),    32'(exp_n6));
            check("vld_clean", 32'(vld_clean), 32'(exp_vld));
            check("vld_n0",    32'(vld_n0),    32'(exp_vld));
            check("vld_n6",    32'(vld_n6),    32'(exp_vld));
            if (strobe) begin
                dev = int'(out_n0) - int'(val);
                st_sum += dev;
                if (dev < 0) dev = -dev;
                if (dev > st_maxdev) st_maxdev = dev;
                if (st_n == 0) st_first = int'(out_n0);
                else if (int'(out_n0) != st_first) st_varied = 1'b1;
                st_n++;
                if (int'(out_n6) < st_min6) st_min6 = int'(out_n6);
                if (int'(out_n6) > st_max6) st_max6 = int'(out_n6);
                if (out_n6 == 16'hFFFF) st_sat6++;
                if (out_n6 == 16'h0000) st_zero6++;
                if (rec_mode == 2 && rec_idx < rec_q.size()) begin
                    check("restart_seq", 32'(out_n0), 32'(rec_q[rec_idx]));
                    rec_idx++;
                end
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        din      = 16'h0000;
        rec_mode = 0;
        rec_idx  = 0;
        model_reset();
        stat_reset();

        // Transparent channel, constant input: first update on the 4th edge
        do_reset();
        run(16, 16'h0001);

        // Transparent channel, input changed mid-period
        do_reset();
        run(6, 16'h0001);
        run(5, 16'h7FFF);
        run(7, 16'hFFFF);
        run(4, 16'h0001);

        // Unscaled noise around mid-scale, 1000 samples
        do_reset();
        stat_reset();
        rec_mode = 1;
        run(4000, 16'h7FFF);
        rec_mode = 0;
        check("t3_samples",   32'(st_n), 32'd1000);
        check("t3_dev_le256", 32'(st_maxdev <= 256), 32'd1);
        check("t3_varied",    32'(st_varied), 32'd1);
        check("t3_mean",      32'((st_sum <= 16 * st_n) && (st_sum >= -16 * st_n)), 32'd1);

        // Maximum noise scale near full scale
        do_reset();
        stat_reset();
        run(800, 16'hFFFF);
        check("t4_min_bound", 32'(st_min6 >= 49151), 32'd1);
        check("t4_saturates", 32'(st_sat6 > 0), 32'd1);

        // Maximum noise scale near zero
        do_reset();
        stat_reset();
        run(800, 16'h0001);
        check("t5_max_bound", 32'(st_max6 <= 16257), 32'd1);
        check("t5_clamps",    32'(st_zero6 > 0), 32'd1);

        // Short reset pulse mid-period, then replay of the post-reset sequence
        run(6, 16'h7FFF);
        mid_reset();
        rec_idx  = 0;
        rec_mode = 2;
        run(64, 16'h7FFF);
        rec_mode = 0;
        check("restart_count", 32'(rec_idx), 32'd16);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
